// File: rtl/rv64im_pkg.sv
// Shared definitions for the RV64IM front end.
// Holds the architectural widths, the default fetch address after reset,
// and the state encoding of the fetch controller.
package rv64im_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // IDLE waits for buffer credit, REQ presents an address to memory,
  // WAIT holds until the single outstanding read returns.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rv64im_inst_fifo.sv
// Instruction buffer between the fetch controller and the core.
// Each entry is {instruction word, PC}. The head entry is read straight
// out of registered storage so the core sees stable data.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i        write pushData_i at the tail
//   pushData_i    entry to write
//   pop_i         drop the head entry
//   flush_i       discard all entries; wins over push and pop
//   count_o       number of valid entries (0..DEPTH)
//   headData_o    oldest entry
module rv64im_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         headData_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q;
  logic [PW-1:0]    wrPtr_q;
  logic [PW:0]      count_q;

  logic doPush;
  logic doPop;

  // Guards keep the buffer consistent even if a caller misbehaves.
  assign doPush = push_i && (count_q != (PW+1)'(DEPTH));
  assign doPop  = pop_i && (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o    = count_q;
  assign headData_o = mem_q[rdPtr_q];

endmodule

// File: rtl/rv64im_fetch_unit.sv
// Instruction fetch stage feeding the RV64IM execute machine.
// Owns the fetch PC, issues one word read at a time to instruction memory,
// buffers returned words with their PCs and hands them to the core in order.
// A redirect from the core flushes the buffer and cancels in-flight work.
//
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   imem_req_valid/ready/addr           read request channel (word aligned)
//   imem_resp_valid/data                read response, one per accepted request
//   redirect_valid/pc                   new fetch target from the core
//   inst_valid/ready, inst_data/pc      instruction handed to the core
module rv64im_fetch_unit
  import rv64im_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [63:0]  fetchPc_q, fetchPc_d;
  logic [63:0]  reqPc_q, reqPc_d;
  logic         drop_q, drop_d;

  logic [CW-1:0] fifoCount;
  logic [95:0]   fifoHead;

  logic          reqFire;
  logic          respFire;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [CW:0]   countAfter;
  logic          creditNow;
  logic          creditAfter;

  assign reqFire  = (state_q == REQ) && imem_req_ready;
  assign respFire = (state_q == WAIT) && imem_resp_valid;
  assign pop      = inst_valid && inst_ready;
  assign push     = respFire && !drop_q && !redirect_valid;

  // A read in flight already owns a buffer slot, so it counts against credit.
  assign occupancy   = {1'b0, fifoCount} + {{CW{1'b0}}, (state_q == WAIT)};
  assign creditNow   = occupancy < (CW+1)'(FIFO_DEPTH);
  assign countAfter  = {1'b0, fifoCount} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
  assign creditAfter = countAfter < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      reqPc_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
      drop_q    <= drop_d;
    end
  end

  // Normal sequencing first; a redirect then overrides it. A response that
  // crosses a redirect is discarded via drop_q so stale words never land.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (creditNow) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (reqFire) begin
          reqPc_d   = fetchPc_q;
          fetchPc_d = fetchPc_q + 64'd4;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          drop_d  = 1'b0;
          state_d = creditAfter ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetchPc_d = redirect_pc & ~64'h3;
      case (state_q)
        REQ: begin
          if (reqFire) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  rv64im_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (96)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushData_i ({imem_resp_data, reqPc_q}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .count_o    (fifoCount),
    .headData_o (fifoHead)
  );

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = fetchPc_q;
  assign inst_valid     = (fifoCount != '0);
  assign inst_data      = fifoHead[95:64];
  assign inst_pc        = fifoHead[63:0];

endmodule
